// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first.
// Optional signed-overflow output V is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] d_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             a;
  logic             b;
  logic             diff;
  logic             bout;
  logic [WIDTH-1:0] d_cat;

  assign a     = a_sr[0];
  assign b     = b_sr[0];
  assign diff  = a ^ b ^ borrow;
  assign bout  = (~a & b) | (~(a ^ b) & borrow);
  // New bit enters at the top; after WIDTH bits this is the full result.
  assign d_cat = {diff, d_sr};

`ifdef SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      B_out  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      V      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SUB_OVERFLOW_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          borrow <= bout;
          d_sr   <= d_cat[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            D     <= d_cat;
            B_out <= bout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef SUB_OVERFLOW_EN
            V     <= (a_msb ^ b_msb) & (diff ^ a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
